// File: rtl/data_inf_c_intc_rr_m2s.sv
// Round-robin merge of NUM valid/ready streams into one registered output stream tagged with the source id.
// Optional packet lock on s_last/m_last: define DATA_INF_C_RR_LAST_LOCK_EN.
module data_inf_c_intc_rr_m2s #(
    parameter int unsigned NUM    = 8,
    parameter int unsigned DSIZE  = 32,
    localparam int unsigned NSIZE = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic [NUM-1:0]       s_valid,
    input  logic [NUM*DSIZE-1:0] s_data,
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
    input  logic [NUM-1:0]       s_last,
    output logic                 m_last,
`endif
    output logic [NUM-1:0]       s_ready,
    output logic                 m_valid,
    output logic [DSIZE-1:0]     m_data,
    output logic [NSIZE-1:0]     m_sid,
    input  logic                 m_ready
);

    logic [NSIZE-1:0] ptr;
    logic [NSIZE-1:0] grant;
    logic             any_valid;
    logic             free;
    logic             accept;
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
    logic             locked;
`endif

    // Scan ptr+1 .. ptr (mod NUM); the highest-priority candidate is written last and wins.
    always_comb begin : arb
        logic [31:0]      idx;
        logic [NSIZE-1:0] idx_n;
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        idx_n     = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            idx = 32'(ptr) + NUM - i;
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            idx_n = NSIZE'(idx);
            if (s_valid[idx_n]) begin
                grant     = idx_n;
                any_valid = 1'b1;
            end
        end
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
        // Mid-packet: ptr still holds the locked source, nobody else may win.
        if (locked) begin
            grant     = ptr;
            any_valid = s_valid[ptr];
        end
`endif
    end

    assign free    = !m_valid || m_ready;
    assign accept  = rst_n && clk_en && free && any_valid;
    assign s_ready = accept ? (NUM'(1) << grant) : '0;

    // Single output register stage; drain and reload may happen on the same edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sid   <= '0;
            ptr     <= NSIZE'(NUM - 1);
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
            m_last  <= 1'b0;
            locked  <= 1'b0;
`endif
        end else if (clk_en) begin
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= s_data[32'(grant)*DSIZE +: DSIZE];
                m_sid   <= grant;
                ptr     <= grant;
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
                m_last  <= s_last[grant];
                locked  <= !s_last[grant];
`endif
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_inf_c_intc_rr_m2s.sv
// Self-checking bench for data_inf_c_intc_rr_m2s (NUM=4, DSIZE=8) against a round-robin reference model.
module tb_data_inf_c_intc_rr_m2s;

    localparam int unsigned NUM   = 4;
    localparam int unsigned DSIZE = 8;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             clk_en;
    logic [3:0]       s_valid;
    logic [31:0]      s_data;
    logic [3:0]       s_ready;
    logic             m_valid;
    logic [7:0]       m_data;
    logic [1:0]       m_sid;
    logic             m_ready;
    logic [7:0]       d [4];
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
    logic [3:0]       s_last;
    logic             m_last;
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit         mv;
    logic [7:0] md;
    logic [1:0] ms;
    logic [1:0] mptr;
    bit         mlock;
    bit         ml;

    assign s_data = {d[3], d[2], d[1], d[0]};
    always #5 clock = ~clock;

    data_inf_c_intc_rr_m2s #(.NUM(NUM), .DSIZE(DSIZE)) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .s_valid (s_valid),
        .s_data  (s_data),
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
        .s_last  (s_last),
        .m_last  (m_last),
`endif
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_sid   (m_sid),
        .m_ready (m_ready)
    );

    function automatic void model_reset();
        mv = 1'b0; md = 8'h00; ms = 2'd0; mptr = 2'd3; mlock = 1'b0; ml = 1'b0;
    endfunction

    // First valid source after the last winner, wrapping around; -1 if nobody may win.
    function automatic int model_winner();
        logic [1:0] j;
        if (mlock) return s_valid[mptr] ? int'(mptr) : -1;
        for (int k = 1; k <= 4; k++) begin
            j = mptr + 2'(k);
            if (s_valid[j]) return int'(j);
        end
        return -1;
    endfunction

    function automatic bit model_accept();
        return rst_n && clk_en && (!mv || m_ready) && (model_winner() >= 0);
    endfunction

    function automatic logic [3:0] exp_ready();
        if (!model_accept()) return 4'b0000;
        return 4'b0001 << model_winner();
    endfunction

    // Advance one clock edge, updating the model with the inputs seen at that edge.
    task automatic cycle();
        int w;
        bit acc;
        @(posedge clock);
        w   = model_winner();
        acc = model_accept();
        if (rst_n && clk_en) begin
            if (acc) begin
                mv = 1'b1; md = d[2'(w)]; ms = 2'(w); mptr = 2'(w);
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
                ml = s_last[2'(w)]; mlock = !s_last[2'(w)];
`endif
            end else if (mv && m_ready) begin
                mv = 1'b0;
            end
        end
        @(negedge clock);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; s_valid = 4'b1111; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) d[k] = 8'(8'h40 + k);
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
        s_last = 4'b1111;
`endif
        model_reset();
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
        checks++; if (m_sid !== 2'd0) begin failures++; $display("FAIL reset_m_sid got=%0d exp=0", m_sid); end
        checks++; if (s_ready !== 4'b0000) begin failures++; $display("FAIL reset_s_ready got=%b exp=0000", s_ready); end
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        checks++; if (s_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_prio got=%b exp=0001", s_ready); end
        @(negedge clock);
    endtask

    task automatic test_single();
        apply_reset();
        s_valid = 4'b0100; d[2] = 8'hA5; m_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", s_ready); end
        cycle();
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_sid !== 2'd2) begin
            failures++; $display("FAIL single_beat got=%b/%h/%0d exp=1/a5/2", m_valid, m_data, m_sid);
        end
        s_valid = 4'b0000;
        cycle();
        checks++; if (m_valid !== 1'b0 || m_data !== 8'hA5) begin
            failures++; $display("FAIL single_drain got=%b/%h exp=0/a5", m_valid, m_data);
        end
    endtask

    task automatic test_rotation();
        int exp_sid [6] = '{0, 1, 2, 3, 0, 1};
        apply_reset();
        s_valid = 4'b1111; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) d[k] = 8'(8'h10 + k);
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (m_valid !== 1'b1 || m_sid !== 2'(exp_sid[i]) || m_data !== 8'(8'h10 + exp_sid[i])) begin
                failures++;
                $display("FAIL rotation_%0d got=%b/%0d/%h exp=1/%0d/%h", i, m_valid, m_sid, m_data,
                         exp_sid[i], 8'(8'h10 + exp_sid[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held_data;
        logic [1:0] held_sid;
        held_data = m_data; held_sid = m_sid;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (s_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_%0d got=%b exp=0000", i, s_ready); end
            cycle();
            checks++; if (m_valid !== 1'b1 || m_data !== held_data || m_sid !== held_sid) begin
                failures++; $display("FAIL bp_hold_%0d got=%b/%h/%0d exp=1/%h/%0d", i, m_valid, m_data, m_sid, held_data, held_sid);
            end
        end
        m_ready = 1'b1;
        cycle();
        checks++; if (m_sid !== held_sid + 2'd1) begin
            failures++; $display("FAIL bp_release got=%0d exp=%0d", m_sid, held_sid + 2'd1);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        m_ready = 1'b1; s_valid = 4'b1000;
        cycle();
        checks++; if (m_sid !== 2'd3) begin failures++; $display("FAIL wrap_setup got=%0d exp=3", m_sid); end
        s_valid = 4'b1001;
        cycle();
        checks++; if (m_sid !== 2'd0) begin failures++; $display("FAIL wrap_3_to_0 got=%0d exp=0", m_sid); end
        cycle();
        checks++; if (m_sid !== 2'd3) begin failures++; $display("FAIL wrap_0_to_3 got=%0d exp=3", m_sid); end
    endtask

    task automatic test_clk_en();
        logic [7:0] held_data;
        logic [1:0] held_sid;
        s_valid = 4'b1111; m_ready = 1'b1;
        cycle();
        held_data = m_data; held_sid = m_sid;
        clk_en = 1'b0;
        #1;
        checks++; if (s_ready !== 4'b0000) begin failures++; $display("FAIL clken_ready got=%b exp=0000", s_ready); end
        cycle();
        checks++; if (m_valid !== 1'b1 || m_data !== held_data || m_sid !== held_sid) begin
            failures++; $display("FAIL clken_hold got=%b/%h/%0d exp=1/%h/%0d", m_valid, m_data, m_sid, held_data, held_sid);
        end
        clk_en = 1'b1;
        cycle();
        checks++; if (m_sid !== held_sid + 2'd1) begin
            failures++; $display("FAIL clken_resume got=%0d exp=%0d", m_sid, held_sid + 2'd1);
        end
    endtask

    task automatic test_async_reset();
        s_valid = 4'b1111; m_ready = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 8'h00 || m_sid !== 2'd0) begin
            failures++; $display("FAIL async_reset got=%b/%h/%0d exp=0/00/0", m_valid, m_data, m_sid);
        end
        @(negedge clock);
        rst_n = 1'b1; m_ready = 1'b1;
        cycle();
        checks++; if (m_valid !== 1'b1 || m_sid !== 2'd0) begin
            failures++; $display("FAIL async_restart got=%b/%0d exp=1/0", m_valid, m_sid);
        end
    endtask

    task automatic test_random();
        logic [3:0] er;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            s_valid = 4'($urandom);
            m_ready = ($urandom % 4) != 0;
            clk_en  = ($urandom % 8) != 0;
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
            s_last = 4'($urandom);
`endif
            #1;
            er = exp_ready();
            checks++; if (s_ready !== er) begin failures++; $display("FAIL rand_ready_%0d got=%b exp=%b", i, s_ready, er); end
            cycle();
            checks++;
            if (m_valid !== mv || m_data !== md || m_sid !== ms) begin
                failures++;
                $display("FAIL rand_out_%0d got=%b/%h/%0d exp=%b/%h/%0d", i, m_valid, m_data, m_sid, mv, md, ms);
            end
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
            checks++; if (m_last !== ml) begin failures++; $display("FAIL rand_last_%0d got=%b exp=%b", i, m_last, ml); end
`endif
        end
        clk_en = 1'b1;
    endtask

`ifdef DATA_INF_C_RR_LAST_LOCK_EN
    task automatic test_lock();
        apply_reset();
        m_ready = 1'b1; s_valid = 4'b0110;
        d[1] = 8'h21; d[2] = 8'h30; s_last = 4'b0100;
        cycle();
        checks++; if (m_sid !== 2'd1 || m_last !== 1'b0) begin failures++; $display("FAIL lock_beat0 got=%0d/%b exp=1/0", m_sid, m_last); end
        d[1] = 8'h22;
        cycle();
        checks++; if (m_sid !== 2'd1 || m_last !== 1'b0 || m_data !== 8'h22) begin
            failures++; $display("FAIL lock_beat1 got=%0d/%b/%h exp=1/0/22", m_sid, m_last, m_data);
        end
        s_valid = 4'b0100;
        #1;
        checks++; if (s_ready !== 4'b0000) begin failures++; $display("FAIL lock_gap_ready got=%b exp=0000", s_ready); end
        cycle();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL lock_gap_valid got=%b exp=0", m_valid); end
        s_valid = 4'b0110; d[1] = 8'h23; s_last = 4'b0110;
        cycle();
        checks++; if (m_sid !== 2'd1 || m_last !== 1'b1 || m_data !== 8'h23) begin
            failures++; $display("FAIL lock_beat2 got=%0d/%b/%h exp=1/1/23", m_sid, m_last, m_data);
        end
        s_valid = 4'b0100;
        cycle();
        checks++; if (m_sid !== 2'd2 || m_data !== 8'h30) begin failures++; $display("FAIL lock_release got=%0d/%h exp=2/30", m_sid, m_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_clk_en();
        test_async_reset();
`ifdef DATA_INF_C_RR_LAST_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
